rf_wr_arbiter: RTL and testbench

//   Owns the single write port of the 31x32 register file and shares it among NREQ writers:
//   req 0 = pipeline WB stage, req 1..NREQ-1 = multi-cycle units (mul/div, CP0/exception).

---
 rtl/rf_wr_arbiter.sv | 97 +++++++++
 tb/tb_rf_wr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: owns the register-file write port; zeroing sweep after reset, then
// fixed priority for requester 0 and round-robin among the rest.
module rf_wr_arbiter #(
    parameter int NREQ       = 3,
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int INIT_SWEEP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    ReqValid,
    input  logic [NREQ*AW-1:0] ReqAddr,
    input  logic [NREQ*DW-1:0] ReqData,
    output logic [NREQ-1:0]    ReqReady,
    output logic               RegWr,
    output logic [AW-1:0]      WrAddr,
    output logic [DW-1:0]      WrData,
    output logic               Busy
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic {INIT, RUN} state_t;

    state_t          state;
    logic [AW-1:0]   ctr;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gidx;
    logic [PW-1:0]   nxt;
    logic [AW-1:0]   gaddr;
    logic [DW-1:0]   gdata;
    logic            found;
    logic            xfer;

    // Round-robin search runs in two passes: ptr..NREQ-1 first, then 1..ptr-1.
    always_comb begin
        ReqReady = '0;
        found    = 1'b0;
        gidx     = '0;
        gaddr    = '0;
        gdata    = '0;
        if (state == RUN) begin
            if (ReqValid[0]) begin
                ReqReady[0] = 1'b1;
            end else begin
                for (int i = 1; i < NREQ; i++)
                    if (!found && ReqValid[i] && i >= int'(ptr)) begin
                        ReqReady[i] = 1'b1;
                        found       = 1'b1;
                    end
                for (int i = 1; i < NREQ; i++)
                    if (!found && ReqValid[i]) begin
                        ReqReady[i] = 1'b1;
                        found       = 1'b1;
                    end
            end
        end
        for (int i = 0; i < NREQ; i++)
            if (ReqReady[i]) begin
                gidx  = PW'(i);
                gaddr = ReqAddr[i*AW +: AW];
                gdata = ReqData[i*DW +: DW];
            end
    end

    assign xfer = |ReqReady;
    assign nxt  = (gidx == PW'(NREQ-1)) ? PW'(1) : gidx + PW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= (INIT_SWEEP != 0) ? INIT : RUN;
            ctr    <= AW'(1);
            ptr    <= PW'(1);
            RegWr  <= 1'b0;
            WrAddr <= '0;
            WrData <= '0;
            Busy   <= 1'b1;
        end else if (state == INIT) begin
            RegWr  <= 1'b1;
            WrAddr <= ctr;
            WrData <= '0;
            ctr    <= ctr + AW'(1);
            if (ctr == '1) begin
                state <= RUN;
                Busy  <= 1'b0;
            end
        end else begin
            Busy  <= 1'b0;
            RegWr <= xfer && (gaddr != '0);
            if (xfer) begin
                WrAddr <= gaddr;
                WrData <= gdata;
            end
            if (xfer && gidx != '0)
                ptr <= nxt;
        end
    end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: scenario tasks plus a randomized run against a queue-free
// behavioural model of the grant rules.
module tb_rf_wr_arbiter;
    localparam int NREQ = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  ReqValid;
    logic [14:0] ReqAddr;
    logic [95:0] ReqData;
    logic [2:0]  ReqReady;
    logic        RegWr;
    logic [4:0]  WrAddr;
    logic [31:0] WrData;
    logic        Busy;

    int tests = 0;
    int fails = 0;

    logic [2:0]  v;
    logic [4:0]  a [3];
    logic [31:0] d [3];
    int          ptr;

    rf_wr_arbiter #(.NREQ(3), .AW(5), .DW(32), .INIT_SWEEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .ReqValid(ReqValid), .ReqAddr(ReqAddr), .ReqData(ReqData),
        .ReqReady(ReqReady), .RegWr(RegWr), .WrAddr(WrAddr), .WrData(WrData), .Busy(Busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected grant: requester 0 wins outright, otherwise the first valid one at or after ptr.
    function automatic int pick(logic [2:0] val, int p);
        if (val[0]) return 0;
        for (int k = 0; k < NREQ - 1; k++) begin
            int i = 1 + (p - 1 + k) % (NREQ - 1);
            if (val[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [2:0] onehot(int g);
        return (g < 0) ? 3'b000 : 3'(1 << g);
    endfunction

    task automatic drive();
        ReqValid = v;
        for (int i = 0; i < NREQ; i++) begin
            ReqAddr[i*5 +: 5]  = a[i];
            ReqData[i*32 +: 32] = d[i];
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        v = 3'b111; a = '{5'd1, 5'd2, 5'd3}; d = '{32'h1, 32'h2, 32'h3};
        drive();
        rst_n = 1'b0;
        tick(); tick();
        tests++;
        if ({RegWr, WrAddr, WrData, Busy} !== {1'b0, 5'd0, 32'd0, 1'b1}) begin
            fails++;
            $display("FAIL reset_outputs: got RegWr=%b WrAddr=%0d WrData=%h Busy=%b, want 0 0 0 1", RegWr, WrAddr, WrData, Busy);
        end
        tests++;
        if (ReqReady !== 3'b000) begin
            fails++;
            $display("FAIL reset_ready: got %b want 000", ReqReady);
        end
        ptr = 1;
    endtask

    task automatic test_sweep();
        rst_n = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            tests++;
            if (ReqReady !== 3'b000) begin
                fails++;
                $display("FAIL sweep_ready[%0d]: got %b want 000", k, ReqReady);
            end
            tick();
            tests++;
            if ({RegWr, WrAddr, WrData, Busy} !== {1'b1, 5'(k), 32'd0, (k < 31)}) begin
                fails++;
                $display("FAIL sweep[%0d]: got RegWr=%b WrAddr=%0d WrData=%h Busy=%b, want 1 %0d 0 %b",
                         k, RegWr, WrAddr, WrData, Busy, k, k < 31);
            end
        end
        v = 3'b000;
        drive();
    endtask

    task automatic test_priority();
        v = 3'b011; a[0] = 5'd5; d[0] = 32'hA5A5_0001; a[1] = 5'd6; d[1] = 32'h0000_0666;
        drive();
        tests++;
        if (ReqReady !== 3'b001) begin
            fails++;
            $display("FAIL prio_ready0: got %b want 001", ReqReady);
        end
        tick();
        tests++;
        if ({RegWr, WrAddr, WrData} !== {1'b1, 5'd5, 32'hA5A5_0001}) begin
            fails++;
            $display("FAIL prio_write0: got %b %0d %h want 1 5 a5a50001", RegWr, WrAddr, WrData);
        end
        v = 3'b010;
        drive();
        tests++;
        if (ReqReady !== 3'b010) begin
            fails++;
            $display("FAIL prio_ready1: got %b want 010", ReqReady);
        end
        tick();
        ptr = 2;
        tests++;
        if ({RegWr, WrAddr, WrData} !== {1'b1, 5'd6, 32'h0000_0666}) begin
            fails++;
            $display("FAIL prio_write1: got %b %0d %h want 1 6 00000666", RegWr, WrAddr, WrData);
        end
        v = 3'b000;
        drive();
        tick();
        tests++;
        if ({RegWr, WrAddr, WrData} !== {1'b0, 5'd6, 32'h0000_0666}) begin
            fails++;
            $display("FAIL idle_hold: got %b %0d %h want 0 6 00000666", RegWr, WrAddr, WrData);
        end
    endtask

    task automatic test_round_robin();
        int g;
        int last = -1;
        v = 3'b110; a[1] = 5'd10; d[1] = 32'h1000_0000; a[2] = 5'd20; d[2] = 32'h2000_0000;
        for (int k = 0; k < 6; k++) begin
            drive();
            g = pick(v, ptr);
            tests++;
            if (ReqReady !== onehot(g) || g == last) begin
                fails++;
                $display("FAIL rr_ready[%0d]: got %b want %b", k, ReqReady, onehot(g));
            end
            tick();
            tests++;
            if ({RegWr, WrAddr, WrData} !== {1'b1, a[g], d[g]}) begin
                fails++;
                $display("FAIL rr_write[%0d]: got %b %0d %h want 1 %0d %h", k, RegWr, WrAddr, WrData, a[g], d[g]);
            end
            ptr = 1 + g % (NREQ - 1);
            last = g;
            a[g] = a[g] + 5'd1;
            d[g] = d[g] + 32'd1;
        end
        v = 3'b000;
        drive();
    endtask

    task automatic test_addr_zero();
        v = 3'b100; a[2] = 5'd0; d[2] = 32'hFFFF_FFFF;
        drive();
        tests++;
        if (ReqReady !== 3'b100) begin
            fails++;
            $display("FAIL a0_ready: got %b want 100", ReqReady);
        end
        tick();
        ptr = 1;
        tests++;
        if (RegWr !== 1'b0) begin
            fails++;
            $display("FAIL a0_regwr: got %b want 0", RegWr);
        end
        v = 3'b110; a[1] = 5'd7; d[1] = 32'h7777_7777; a[2] = 5'd8; d[2] = 32'h8888_8888;
        drive();
        tests++;
        if (ReqReady !== 3'b010) begin
            fails++;
            $display("FAIL a0_ptr: got %b want 010", ReqReady);
        end
        tick();
        ptr = 2;
        v = 3'b000;
        drive();
    endtask

    task automatic test_reset_mid_sweep();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 11; k++) tick();
        tests++;
        if ({RegWr, WrAddr, Busy} !== {1'b1, 5'd11, 1'b1}) begin
            fails++;
            $display("FAIL mid_sweep_pos: got %b %0d %b want 1 11 1", RegWr, WrAddr, Busy);
        end
        rst_n = 1'b0;
        tick();
        tests++;
        if ({RegWr, WrAddr, WrData, Busy} !== {1'b0, 5'd0, 32'd0, 1'b1}) begin
            fails++;
            $display("FAIL mid_sweep_reset: got %b %0d %h %b want 0 0 0 1", RegWr, WrAddr, WrData, Busy);
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if ({RegWr, WrAddr, Busy} !== {1'b1, 5'd1, 1'b1}) begin
            fails++;
            $display("FAIL sweep_restart: got %b %0d %b want 1 1 1", RegWr, WrAddr, Busy);
        end
        for (int k = 0; k < 30; k++) tick();
        ptr = 1;
        tests++;
        if ({WrAddr, Busy} !== {5'd31, 1'b0}) begin
            fails++;
            $display("FAIL sweep_end: got %0d %b want 31 0", WrAddr, Busy);
        end
    endtask

    task automatic test_reset_mid_transfer();
        v = 3'b010; a[1] = 5'd9; d[1] = 32'h9999_9999;
        drive();
        tests++;
        if (ReqReady !== 3'b010) begin
            fails++;
            $display("FAIL xfer_ready: got %b want 010", ReqReady);
        end
        rst_n = 1'b0;
        tick();
        tests++;
        if ({RegWr, WrAddr, WrData} !== {1'b0, 5'd0, 32'd0}) begin
            fails++;
            $display("FAIL xfer_reset: got %b %0d %h want 0 0 0", RegWr, WrAddr, WrData);
        end
        v = 3'b000;
        drive();
        rst_n = 1'b1;
        for (int k = 0; k < 31; k++) tick();
        ptr = 1;
    endtask

    task automatic test_random();
        int g;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!v[i] && $urandom_range(0, (i == 0) ? 3 : 1) == 0) begin
                    v[i] = 1'b1;
                    a[i] = 5'($urandom_range(0, 31));
                    d[i] = $urandom;
                end
            drive();
            g = pick(v, ptr);
            tests++;
            if (ReqReady !== onehot(g)) begin
                fails++;
                $display("FAIL rand_ready[%0d]: got %b want %b (valid %b ptr %0d)", c, ReqReady, onehot(g), v, ptr);
            end
            tick();
            tests++;
            if (g < 0 || a[g] == 5'd0) begin
                if (RegWr !== 1'b0) begin
                    fails++;
                    $display("FAIL rand_nowrite[%0d]: got RegWr=%b want 0", c, RegWr);
                end
            end else if ({RegWr, WrAddr, WrData} !== {1'b1, a[g], d[g]}) begin
                fails++;
                $display("FAIL rand_write[%0d]: got %b %0d %h want 1 %0d %h", c, RegWr, WrAddr, WrData, a[g], d[g]);
            end
            if (g >= 0) begin
                v[g] = 1'b0;
                if (g > 0) ptr = 1 + g % (NREQ - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_priority();
        test_round_robin();
        test_addr_zero();
        test_reset_mid_sweep();
        test_reset_mid_transfer();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
